// File: rtl/divider_seq_pkg.sv
// divider_seq_pkg: shared state encoding for the sequential divider.
package divider_seq_pkg;
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ITER = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_e;
endpackage

// File: rtl/divider_step.sv
// divider_step: one restoring-division step (shift in a dividend bit, trial subtract).
module divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);
    logic [WIDTH+1:0] shifted, trial;
    assign shifted  = {rem, bit_in};
    assign trial    = shifted - {2'b00, divisor};
    assign q_bit    = ~trial[WIDTH+1];
    assign rem_next = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
endmodule

// File: rtl/divider_seq.sv
// divider_seq: iterative signed/unsigned restoring divider, one quotient bit per clock; DIVIDER_SEQ_EARLY_EXIT_EN skips iteration when |dividend| < |divisor|.
module divider_seq
    import divider_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic             in_clk,
    input  logic             in_clr,
    input  logic             in_start,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             out_busy,
    output logic             out_done,
    output logic             out_div_zero,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder
);
    div_state_e state, state_nxt;
    logic [WIDTH:0]   rem, rem_nxt;
    logic [WIDTH-1:0] dvd, dsr, dvd_abs, dsr_abs, r_mag;
    logic [CNT_W-1:0] cnt;
    logic             sign_q, sign_r, dz, q_bit, early, accept, zero_dsr;

    assign accept   = state == DIV_IDLE && in_start;
    assign zero_dsr = in_divisor == '0;
    assign dvd_abs  = in_signed && in_dividend[WIDTH-1] ? -in_dividend : in_dividend;
    assign dsr_abs  = in_signed && in_divisor[WIDTH-1] ? -in_divisor : in_divisor;
`ifdef DIVIDER_SEQ_EARLY_EXIT_EN
    assign early    = dvd_abs < dsr_abs;
`else
    assign early    = 1'b0;
`endif
    assign r_mag    = dz ? dvd : rem[WIDTH-1:0];
    assign out_busy = state != DIV_IDLE;

    divider_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .bit_in  (dvd[WIDTH-1]),
        .divisor (dsr),
        .rem_next(rem_nxt),
        .q_bit   (q_bit)
    );

    always_ff @(posedge in_clk or posedge in_clr)
        if (in_clr) state <= DIV_IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = DIV_IDLE;
        if (state == DIV_IDLE)
            state_nxt = !in_start ? DIV_IDLE : (zero_dsr || early) ? DIV_FIX : DIV_ITER;
        else if (state == DIV_ITER)
            state_nxt = cnt == CNT_W'(WIDTH-1) ? DIV_FIX : DIV_ITER;
    end

    always_ff @(posedge in_clk or posedge in_clr) begin
        if (in_clr) begin
            rem           <= '0;
            dvd           <= '0;
            dsr           <= '0;
            cnt           <= '0;
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
            dz            <= 1'b0;
            out_done      <= 1'b0;
            out_div_zero  <= 1'b0;
            out_quotient  <= '0;
            out_remainder <= '0;
        end else begin
            out_done <= state == DIV_FIX;
            if (accept) begin
                rem          <= early ? {1'b0, dvd_abs} : '0;
                dvd          <= early ? '0 : dvd_abs;
                dsr          <= dsr_abs;
                cnt          <= '0;
                sign_q       <= in_signed & (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]);
                sign_r       <= in_signed & in_dividend[WIDTH-1];
                dz           <= zero_dsr;
                out_div_zero <= 1'b0;
            end else if (state == DIV_ITER) begin
                rem <= rem_nxt;
                dvd <= {dvd[WIDTH-2:0], q_bit};
                cnt <= cnt + CNT_W'(1);
            end else if (state == DIV_FIX) begin
                out_quotient  <= dz ? '1 : sign_q ? -dvd : dvd;
                out_remainder <= sign_r ? -r_mag : r_mag;
                out_div_zero  <= dz;
            end
        end
    end
endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: table-driven and sequence checks for divider_seq at WIDTH=32.
module tb_divider_seq;
`ifdef DIVIDER_SEQ_EARLY_EXIT_EN
    localparam int EE = 2;
`else
    localparam int EE = 34;
`endif
    logic        clk = 1'b0;
    logic        clr, start, sgn;
    logic [31:0] a, b;
    logic        busy, done, dzf;
    logic [31:0] q, r;
    int checks = 0;
    int failures = 0;

    divider_seq #(.WIDTH(32)) dut (
        .in_clk       (clk),
        .in_clr       (clr),
        .in_start     (start),
        .in_signed    (sgn),
        .in_dividend  (a),
        .in_divisor   (b),
        .out_busy     (busy),
        .out_done     (done),
        .out_div_zero (dzf),
        .out_quotient (q),
        .out_remainder(r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t v[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat = 1;
        busy_n = 0;
        while (!done && lat < 100) begin
            if (busy) busy_n++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("busy_with_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                         output int lat, output int busy_n);
        @(negedge clk);
        a = x;
        b = y;
        sgn = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, busy_n);
    endtask

    initial begin
        int lat, bn;
        logic seen;
        v[0]  = '{32'd30,       32'd4,        1'b1, 32'd7,        32'd2,        1'b0, 34};
        v[1]  = '{32'd10,       32'hFFFFFFFD, 1'b1, 32'hFFFFFFFD, 32'd1,        1'b0, 34};
        v[2]  = '{32'hFFFFFE0C, 32'd3,        1'b1, 32'hFFFFFF5A, 32'hFFFFFFFE, 1'b0, 34};
        v[3]  = '{32'hFFFFFF9C, 32'hFFFFFFF7, 1'b1, 32'd11,       32'hFFFFFFFF, 1'b0, 34};
        v[4]  = '{32'hFFFFFFFF, 32'd2,        1'b0, 32'h7FFFFFFF, 32'd1,        1'b0, 34};
        v[5]  = '{32'hFFFFFFFF, 32'd2,        1'b1, 32'd0,        32'hFFFFFFFF, 1'b0, EE};
        v[6]  = '{32'h1234,     32'd0,        1'b1, 32'hFFFFFFFF, 32'h1234,     1'b1, 2};
        v[7]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0, 34};
        v[8]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, 34};
        v[9]  = '{32'hFFFFFF00, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFF00, 1'b1, 2};
        v[10] = '{32'd34,       32'd36,       1'b0, 32'd0,        32'd34,       1'b0, EE};

        clr = 1'b1;
        start = 1'b0;
        sgn = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", q, 32'd0);
        chk("rst_r", r, 32'd0);
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_op(v[i].a, v[i].b, v[i].s, lat, bn);
            chk($sformatf("v%0d_q", i), q, v[i].q);
            chk($sformatf("v%0d_r", i), r, v[i].r);
            chk($sformatf("v%0d_dz", i), {31'd0, dzf}, {31'd0, v[i].dz});
            chk($sformatf("v%0d_lat", i), lat, v[i].lat);
            chk($sformatf("v%0d_busy", i), bn, v[i].lat - 1);
        end

        // start held high through busy; operands changed mid-flight must be ignored
        @(negedge clk);
        a = 32'd30;
        b = 32'd4;
        sgn = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 32'd100;
        b = 32'd7;
        wait_done(lat, bn);
        chk("hold_lat", lat, 34);
        chk("hold_q", q, 32'd7);
        chk("hold_r", r, 32'd2);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bn);
        chk("b2b_lat", lat, 34);
        chk("b2b_q", q, 32'd14);
        chk("b2b_r", r, 32'd2);

        // reset aborts an operation in flight
        @(negedge clk);
        a = 32'd30;
        b = 32'd4;
        sgn = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        clr = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_q", q, 32'd0);
        chk("abort_r", r, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen = seen | done;
        end
        chk("abort_no_done", {31'd0, seen}, 32'd0);
        do_op(32'd30, 32'd4, 1'b1, lat, bn);
        chk("post_abort_q", q, 32'd7);
        chk("post_abort_r", r, 32'd2);
        chk("post_abort_lat", lat, 34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
